// File: rtl/ifft_butterfly_pipe.sv
// ---------------------------------------------------------------------------
// ifft_butterfly_pipe
//
// Pipelined radix-2 inverse butterfly on Q1.15 complex operands:
//   y1 = (A + B) / 2
//   y2 = ((A - B) * conj(W)) / 2
// Three register stages (S1 sum/diff, S2 partial products, S3 combine +
// round + saturate) advance together on a single enable, giving one
// butterfly per cycle with full backpressure and a fixed 3-cycle latency.
//
// Handshake: a transfer happens on a cycle where valid && ready are both
// high at the rising edge. The source holds in_* stable while in_valid is
// high and in_ready is low; the block holds out_* stable while out_valid is
// high and out_ready is low. in_ready is combinational from out_ready (no
// skid buffer), so accept and deliver in the same cycle are legal.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      operand set handshake
//   in_a_*, in_b_*           operands A and B, signed Q1.15
//   in_w_*                   twiddle W (conjugated internally), signed Q1.15
//   in_tag                   opaque tag carried with the operation
//   out_valid / out_ready    result handshake
//   out_y1_*, out_y2_*       results, Q1.15
//   out_tag                  tag of the presented result
//   sat_flag                 sticky, set when any y2 component clipped
//   sat_clr                  synchronous clear of sat_flag (set wins)
//   stage_valid              debug view of the valid chain {v3, v2, v1}
// ---------------------------------------------------------------------------
module ifft_butterfly_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a_re,
  input  logic [15:0]      in_a_im,
  input  logic [15:0]      in_b_re,
  input  logic [15:0]      in_b_im,
  input  logic [15:0]      in_w_re,
  input  logic [15:0]      in_w_im,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_y1_re,
  output logic [15:0]      out_y1_im,
  output logic [15:0]      out_y2_re,
  output logic [15:0]      out_y2_im,
  output logic [TAG_W-1:0] out_tag,
  output logic             sat_flag,
  input  logic             sat_clr,
  output logic [2:0]       stage_valid
);

  // Round half up and drop 16 fraction bits (this folds in the x1/2),
  // then clip to the Q1.15 range. Returns {clipped, value}.
  // floor((p + 2^15) / 2^16) equals p[33:16] plus the carry p[15].
  function automatic logic [16:0] round_sat(input logic signed [33:0] p);
    logic signed [17:0] q;
    q = $signed(p[33:16]) + $signed({17'd0, p[15]});
    if (q > 18'sd32767) begin
      round_sat = {1'b1, 16'h7FFF};
    end else if (q < -18'sd32768) begin
      round_sat = {1'b1, 16'h8000};
    end else begin
      round_sat = {1'b0, q[15:0]};
    end
  endfunction

  logic v1, v2, v3;
  logic adv;

  // S1 registers
  logic signed [16:0] s1_re, s1_im, d1_re, d1_im;
  logic signed [15:0] w1_re, w1_im;
  logic [TAG_W-1:0]   tag1;

  // S2 registers
  logic signed [16:0] s2_re, s2_im;
  logic signed [32:0] p_rr, p_ii, p_ir, p_ri;
  logic [TAG_W-1:0]   tag2;

  // S3 combinational inputs
  logic signed [33:0] p_re, p_im;
  logic [16:0]        y2_re_rs, y2_im_rs;
  logic [16:0]        y1_re_sum, y1_im_sum;
  logic               clip;

  // The whole pipe freezes only when a result sits in S3 unaccepted.
  assign adv         = !(v3 && !out_ready);
  assign in_ready    = adv;
  assign out_valid   = v3;
  assign stage_valid = {v3, v2, v1};

  always_comb begin
    p_re      = 34'(p_rr) + 34'(p_ii);
    p_im      = 34'(p_ir) - 34'(p_ri);
    y2_re_rs  = round_sat(p_re);
    y2_im_rs  = round_sat(p_im);
    // (s + 1) >>> 1 : s+1 fits 17 bits, the upper 16 bits are the result.
    y1_re_sum = s2_re + 17'sd1;
    y1_im_sum = s2_im + 17'sd1;
    clip      = y2_re_rs[16] | y2_im_rs[16];
  end

  // Valid chain
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // S1: full-precision sum and difference, no truncation.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_re <= '0;
      s1_im <= '0;
      d1_re <= '0;
      d1_im <= '0;
      w1_re <= '0;
      w1_im <= '0;
      tag1  <= '0;
    end else if (adv) begin
      s1_re <= {in_a_re[15], in_a_re} + {in_b_re[15], in_b_re};
      s1_im <= {in_a_im[15], in_a_im} + {in_b_im[15], in_b_im};
      d1_re <= {in_a_re[15], in_a_re} - {in_b_re[15], in_b_re};
      d1_im <= {in_a_im[15], in_a_im} - {in_b_im[15], in_b_im};
      w1_re <= in_w_re;
      w1_im <= in_w_im;
      tag1  <= in_tag;
    end
  end

  // S2: the four partial products of d * conj(w).
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_re <= '0;
      s2_im <= '0;
      p_rr  <= '0;
      p_ii  <= '0;
      p_ir  <= '0;
      p_ri  <= '0;
      tag2  <= '0;
    end else if (adv) begin
      s2_re <= s1_re;
      s2_im <= s1_im;
      p_rr  <= 33'(d1_re) * 33'(w1_re);
      p_ii  <= 33'(d1_im) * 33'(w1_im);
      p_ir  <= 33'(d1_im) * 33'(w1_re);
      p_ri  <= 33'(d1_re) * 33'(w1_im);
      tag2  <= tag1;
    end
  end

  // S3: output registers, which are also the presented result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_y1_re <= '0;
      out_y1_im <= '0;
      out_y2_re <= '0;
      out_y2_im <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      out_y1_re <= y1_re_sum[16:1];
      out_y1_im <= y1_im_sum[16:1];
      out_y2_re <= y2_re_rs[15:0];
      out_y2_im <= y2_im_rs[15:0];
      out_tag   <= tag2;
    end
  end

  // Sticky saturation flag; a clipping load in the same cycle beats sat_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (adv && v2 && clip) begin
      sat_flag <= 1'b1;
    end else if (sat_clr) begin
      sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ifft_butterfly_pipe.sv
// ---------------------------------------------------------------------------
// Testbench for ifft_butterfly_pipe. Inputs change on the falling edge;
// accepts and deliveries are recorded 1 ns later, before the next rising
// edge. Expected results come from an integer model of the butterfly
// equations and from hand-computed constants for the directed cases.
// ---------------------------------------------------------------------------
module tb_ifft_butterfly_pipe;
  localparam int TAG_W = 4;
  localparam int RW    = TAG_W + 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a_re, in_a_im, in_b_re, in_b_im, in_w_re, in_w_im;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_y1_re, out_y1_im, out_y2_re, out_y2_im;
  logic [TAG_W-1:0] out_tag;
  logic             sat_flag;
  logic             sat_clr;
  logic [2:0]       stage_valid;

  ifft_butterfly_pipe #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a_re(in_a_re), .in_a_im(in_a_im),
    .in_b_re(in_b_re), .in_b_im(in_b_im),
    .in_w_re(in_w_re), .in_w_im(in_w_im),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y1_re(out_y1_re), .out_y1_im(out_y1_im),
    .out_y2_re(out_y2_re), .out_y2_im(out_y2_im),
    .out_tag(out_tag),
    .sat_flag(sat_flag), .sat_clr(sat_clr),
    .stage_valid(stage_valid)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_q[$];
  int            acc_cyc[$];
  int            del_cyc[$];
  logic          exp_sat;
  int            cyc;
  int            n_cmp;
  int            n_err;

  // Reference model: {sat, tag, y1_re, y1_im, y2_re, y2_im}
  function automatic logic [RW:0] model(input logic [15:0] ar, ai, br, bi, wr, wi,
                                        input logic [TAG_W-1:0] tg);
    longint sr, si, dr, di, pr, pi, y1r, y1i, y2r, y2i;
    logic   sat;
    sr  = longint'($signed(ar)) + longint'($signed(br));
    si  = longint'($signed(ai)) + longint'($signed(bi));
    dr  = longint'($signed(ar)) - longint'($signed(br));
    di  = longint'($signed(ai)) - longint'($signed(bi));
    // d * conj(w) = (dr + j di)(wr - j wi)
    pr  = dr * longint'($signed(wr)) + di * longint'($signed(wi));
    pi  = di * longint'($signed(wr)) - dr * longint'($signed(wi));
    y1r = (sr + 1) >>> 1;
    y1i = (si + 1) >>> 1;
    y2r = (pr + 32768) >>> 16;
    y2i = (pi + 32768) >>> 16;
    sat = 1'b0;
    if (y2r > 32767)  begin y2r = 32767;  sat = 1'b1; end
    if (y2r < -32768) begin y2r = -32768; sat = 1'b1; end
    if (y2i > 32767)  begin y2i = 32767;  sat = 1'b1; end
    if (y2i < -32768) begin y2i = -32768; sat = 1'b1; end
    return {sat, tg, y1r[15:0], y1i[15:0], y2r[15:0], y2i[15:0]};
  endfunction

  // driver tasks
  task automatic set_op(input logic [15:0] ar, ai, br, bi, wr, wi,
                        input logic [TAG_W-1:0] tg);
    in_a_re = ar; in_a_im = ai; in_b_re = br; in_b_im = bi;
    in_w_re = wr; in_w_im = wi; in_tag = tg;
  endtask

  task automatic set_rand_op(input logic [TAG_W-1:0] tg);
    set_op(16'($urandom()), 16'($urandom()), 16'($urandom()),
           16'($urandom()), 16'($urandom()), 16'($urandom()), tg);
  endtask

  // One clock: record handshakes with settled inputs, then advance to the
  // next falling edge.
  task automatic cycle();
    logic [RW:0] m;
    #1;
    if (!rst && in_valid && in_ready) begin
      m = model(in_a_re, in_a_im, in_b_re, in_b_im, in_w_re, in_w_im, in_tag);
      exp_q.push_back(m[RW-1:0]);
      exp_sat = exp_sat | m[RW];
      acc_cyc.push_back(cyc);
    end
    if (!rst && out_valid && out_ready) begin
      got_q.push_back({out_tag, out_y1_re, out_y1_im, out_y2_re, out_y2_im});
      del_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_sb();
    exp_q.delete(); got_q.delete(); acc_cyc.delete(); del_cyc.delete();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && got_q.size() < exp_q.size(); i++) cycle();
    for (int i = 0; i < 2; i++) cycle();
  endtask

  task automatic test_reset();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_cmp++;
    if ({out_tag, out_y1_re, out_y1_im, out_y2_re, out_y2_im} !== '0) begin
      n_err++;
      $display("FAIL reset_data got=%h want=0", {out_tag, out_y1_re, out_y1_im, out_y2_re, out_y2_im});
    end
    n_cmp++;
    if (sat_flag !== 1'b0) begin n_err++; $display("FAIL reset_sat got=%b want=0", sat_flag); end
    n_cmp++;
    if (stage_valid !== 3'b000) begin n_err++; $display("FAIL reset_stage_valid got=%b want=000", stage_valid); end
  endtask

  task automatic test_basic();
    clear_sb();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_op(16'h4000, 16'h0000, 16'h2000, 16'h0000, 16'h7FFF, 16'h0000, 4'h1);
    cycle();
    drain();
    n_cmp++;
    if (got_q.size() != 1) begin
      n_err++; $display("FAIL basic_count got=%0d want=1", got_q.size());
    end else begin
      n_cmp++;
      if (got_q[0] !== {4'h1, 16'h3000, 16'h0000, 16'h1000, 16'h0000}) begin
        n_err++; $display("FAIL basic_result got=%h want=%h", got_q[0], {4'h1, 16'h3000, 16'h0000, 16'h1000, 16'h0000});
      end
      n_cmp++;
      if (del_cyc[0] - acc_cyc[0] != 3) begin
        n_err++; $display("FAIL basic_latency got=%0d want=3", del_cyc[0] - acc_cyc[0]);
      end
    end
    n_cmp++;
    if (sat_flag !== 1'b0) begin n_err++; $display("FAIL basic_sat got=%b want=0", sat_flag); end
  endtask

  task automatic test_conjugate();
    clear_sb();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_op(16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 4'h2);
    cycle();
    drain();
    n_cmp++;
    if (got_q.size() != 1) begin
      n_err++; $display("FAIL conj_count got=%0d want=1", got_q.size());
    end else begin
      n_cmp++;
      if (got_q[0] !== {4'h2, 16'h2000, 16'h0000, 16'h0000, 16'hE000}) begin
        n_err++; $display("FAIL conj_result got=%h want=%h", got_q[0], {4'h2, 16'h2000, 16'h0000, 16'h0000, 16'hE000});
      end
    end
  endtask

  task automatic test_saturation();
    clear_sb();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_op(16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 4'h3);
    cycle();
    drain();
    n_cmp++;
    if (got_q.size() != 1) begin
      n_err++; $display("FAIL sat_count got=%0d want=1", got_q.size());
    end else begin
      n_cmp++;
      if (got_q[0] !== {4'h3, 16'h0000, 16'h0000, 16'h8000, 16'h0000}) begin
        n_err++; $display("FAIL sat_result got=%h want=%h", got_q[0], {4'h3, 16'h0000, 16'h0000, 16'h8000, 16'h0000});
      end
    end
    n_cmp++;
    if (sat_flag !== 1'b1) begin n_err++; $display("FAIL sat_set got=%b want=1", sat_flag); end
    for (int i = 0; i < 3; i++) cycle();
    n_cmp++;
    if (sat_flag !== 1'b1) begin n_err++; $display("FAIL sat_hold got=%b want=1", sat_flag); end
    sat_clr = 1'b1;
    cycle();
    sat_clr = 1'b0;
    exp_sat = 1'b0;
    n_cmp++;
    if (sat_flag !== 1'b0) begin n_err++; $display("FAIL sat_clear got=%b want=0", sat_flag); end
  endtask

  task automatic test_back_to_back();
    clear_sb();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      set_rand_op(TAG_W'(i));
      cycle();
    end
    drain();
    n_cmp++;
    if (got_q.size() != 16 || exp_q.size() != 16) begin
      n_err++; $display("FAIL stream_count got=%0d want=16 (accepted %0d)", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i] || got_q[i][RW-1 -: TAG_W] !== TAG_W'(i)) begin
          n_err++; $display("FAIL stream_result[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
        end
        n_cmp++;
        if (del_cyc[i] != acc_cyc[0] + 3 + i) begin
          n_err++; $display("FAIL stream_timing[%0d] got=%0d want=%0d", i, del_cyc[i], acc_cyc[0] + 3 + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int   sent;
    int   stall_left;
    logic started;
    logic [RW-1:0] snap;
    clear_sb();
    sent       = 0;
    stall_left = 0;
    started    = 1'b0;
    snap       = '0;
    set_rand_op(TAG_W'(0));
    for (int k = 0; k < 40 && !(sent == 4 && got_q.size() == 4); k++) begin
      if (!started && out_valid) begin
        started    = 1'b1;
        stall_left = 5;
        snap       = {out_tag, out_y1_re, out_y1_im, out_y2_re, out_y2_im};
      end
      out_ready = (stall_left == 0);
      in_valid  = (sent < 4);
      #1;
      if (stall_left > 0) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
        n_cmp++;
        if ({out_tag, out_y1_re, out_y1_im, out_y2_re, out_y2_im} !== snap || out_valid !== 1'b1) begin
          n_err++;
          $display("FAIL bp_hold got=%h want=%h", {out_tag, out_y1_re, out_y1_im, out_y2_re, out_y2_im}, snap);
        end
      end
      cycle();
      if (exp_q.size() > sent) begin
        sent = exp_q.size();
        set_rand_op(TAG_W'(sent));
      end
      if (stall_left > 0) stall_left--;
    end
    drain();
    n_cmp++;
    if (got_q.size() != 4 || exp_q.size() != 4) begin
      n_err++; $display("FAIL bp_count got=%0d want=4 (accepted %0d)", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i] || got_q[i][RW-1 -: TAG_W] !== TAG_W'(i)) begin
          n_err++; $display("FAIL bp_result[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic pend;
    int   ntag;
    clear_sb();
    sat_clr = 1'b1;
    cycle();
    sat_clr = 1'b0;
    exp_sat = 1'b0;
    pend    = 1'b0;
    ntag    = 0;
    for (int k = 0; k < 400 && exp_q.size() < 60; k++) begin
      if (!pend) begin
        pend = ($urandom_range(0, 3) != 0);
        if (pend) begin
          // Occasionally force the clipping corner so the sticky flag is exercised.
          if ($urandom_range(0, 9) == 0)
            set_op(16'h7FFF, 16'($urandom()), 16'h8000, 16'($urandom()), 16'h8000, 16'h8000, TAG_W'(ntag));
          else
            set_rand_op(TAG_W'(ntag));
        end
      end
      in_valid  = pend;
      out_ready = ($urandom_range(0, 3) != 0);
      ntag      = exp_q.size();
      cycle();
      if (exp_q.size() != ntag) begin
        pend = 1'b0;
        ntag = exp_q.size();
      end
    end
    drain();
    n_cmp++;
    if (got_q.size() != exp_q.size() || exp_q.size() == 0) begin
      n_err++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL rand_result[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
    n_cmp++;
    if (sat_flag !== exp_sat) begin n_err++; $display("FAIL rand_sat got=%b want=%b", sat_flag, exp_sat); end
  endtask

  task automatic test_reset_midflight();
    clear_sb();
    // Leave the sticky flag set so reset has something to clear.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_op(16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 4'h9);
    cycle();
    drain();
    n_cmp++;
    if (sat_flag !== 1'b1) begin n_err++; $display("FAIL mid_presat got=%b want=1", sat_flag); end
    clear_sb();
    in_valid = 1'b1;
    set_rand_op(4'hA);
    cycle();
    set_rand_op(4'hB);
    cycle();
    rst      = 1'b1;
    sat_clr  = 1'b1;
    in_valid = 1'b1;
    cycle();
    rst      = 1'b0;
    sat_clr  = 1'b0;
    in_valid = 1'b0;
    exp_sat  = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid got=%b want=0", out_valid); end
    n_cmp++;
    if ({out_tag, out_y1_re, out_y1_im, out_y2_re, out_y2_im} !== '0) begin
      n_err++;
      $display("FAIL mid_data got=%h want=0", {out_tag, out_y1_re, out_y1_im, out_y2_re, out_y2_im});
    end
    n_cmp++;
    if (sat_flag !== 1'b0) begin n_err++; $display("FAIL mid_sat got=%b want=0", sat_flag); end
    got_q.delete();
    for (int i = 0; i < 8; i++) cycle();
    n_cmp++;
    if (got_q.size() != 0) begin n_err++; $display("FAIL mid_discard got=%0d want=0", got_q.size()); end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    cyc       = 0;
    exp_sat   = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    set_op('0, '0, '0, '0, '0, '0, '0);
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_conjugate();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
